// File: rtl/alu_status_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_status_stage
//  Description : Two-stage valid/ready execute stage. S1 holds operands, S2
//                holds the result C and the {V,N,Z} status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_status_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] sout,
    input  logic             asel,
    input  logic [1:0]       alu_op,
    input  logic             write_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic [2:0]       status
);

    localparam logic [1:0]       c_OP_ADD = 2'b00;
    localparam logic [1:0]       c_OP_SUB = 2'b01;
    localparam logic [1:0]       c_OP_AND = 2'b10;
    localparam logic [1:0]       c_OP_NOT = 2'b11;
    localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [1:0]       r_s1_op;
    logic             r_s1_ws;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_c_out;
    logic [2:0]       r_status;

    logic             w_advance_s2;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic [2:0]       w_status_next;

    // S1 may refill in the same cycle it drains into S2, so no bubble.
    assign w_advance_s2 = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready     = ~r_s1_valid | w_advance_s2;
    assign w_accept     = in_valid & in_ready;

    assign w_sum  = r_s1_a + r_s1_b;
    assign w_diff = r_s1_a + ~r_s1_b + c_ONE;

    always_comb begin
        w_result = w_sum;
        w_ovf    = 1'b0;
        case (r_s1_op)
            c_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &
                           (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &
                           (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            c_OP_AND: w_result = r_s1_a & r_s1_b;
            c_OP_NOT: w_result = ~r_s1_b;
            default:  w_result = w_sum;
        endcase
        w_status_next = {w_ovf, w_result[WIDTH-1], (w_result == '0)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= 2'b00;
            r_s1_ws     <= 1'b0;
            r_out_valid <= 1'b0;
            r_c_out     <= '0;
            r_status    <= 3'b000;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= asel ? '0 : ain;
                r_s1_b     <= sout;
                r_s1_op    <= alu_op;
                r_s1_ws    <= write_status;
            end else if (w_advance_s2) begin
                r_s1_valid <= 1'b0;
            end

            if (w_advance_s2) begin
                r_out_valid <= 1'b1;
                r_c_out     <= w_result;
                if (r_s1_ws) begin
                    r_status <= w_status_next;
                end
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c_out     = r_c_out;
    assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_status_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_status_stage
//  Description : Self-checking bench: directed vector table, corner sequences
//                and randomized traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_status_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ain;
    logic [W-1:0] sout;
    logic         asel;
    logic [1:0]   alu_op;
    logic         write_status;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c_out;
    logic [2:0]   status;

    alu_status_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ain          (ain),
        .sout         (sout),
        .asel         (asel),
        .alu_op       (alu_op),
        .write_status (write_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .c_out        (c_out),
        .status       (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         asel;
        logic [1:0]   op;
        logic         ws;
        logic [W-1:0] exp_c;
        logic [2:0]   exp_st;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic [2:0]   st;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic [2:0] m_status = 3'b000;
    logic last_acc;
    int   pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int to_int(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Reference: exact signed arithmetic, overflow = true result out of range.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic as, input logic [1:0] op, input logic ws);
        res_t r;
        int   ap, bp, t;
        logic v;
        logic [W-1:0] a_eff;
        a_eff = as ? '0 : a;
        ap = to_int(a_eff);
        bp = to_int(b);
        v  = 1'b0;
        case (op)
            2'd0: begin t = ap + bp; v = (t > 32767) || (t < -32768); r.c = W'(t); end
            2'd1: begin t = ap - bp; v = (t > 32767) || (t < -32768); r.c = W'(t); end
            2'd2: r.c = a_eff & b;
            default: r.c = ~b;
        endcase
        if (ws) m_status = {v, (ap_neg(r.c)), (r.c == 0)};
        r.st = m_status;
        return r;
    endfunction

    function automatic logic ap_neg(input logic [W-1:0] v);
        return to_int(v) < 0;
    endfunction

    task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic as, input logic [1:0] op, input logic ws);
        in_valid = v; ain = a; sout = b; asel = as; alu_op = op; write_status = ws;
    endtask

    // One clock: evaluate handshakes just before the edge, update model, advance.
    task automatic cycle();
        res_t e;
        #1;
        last_acc = in_valid & in_ready;
        if (last_acc) exp_q.push_back(model(ain, sout, asel, alu_op, write_status));
        if (out_valid & out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("spurious_output", 32'(out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_c_out", 32'(c_out), 32'(e.c));
                chk("sb_status", 32'(status), 32'(e.st));
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 2'd0, 1'b1, 16'h8000, 3'b110};
        vecs[1] = '{16'h0005, 16'h0005, 1'b0, 2'd1, 1'b1, 16'h0000, 3'b001};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 2'd1, 1'b1, 16'h7FFF, 3'b100};
        vecs[3] = '{16'hF0CF, 16'hBAB7, 1'b0, 2'd2, 1'b0, 16'hB087, 3'b100};
        vecs[4] = '{16'h1234, 16'hFFFF, 1'b1, 2'd3, 1'b1, 16'h0000, 3'b001};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 2'd0, 1'b1, 16'h0000, 3'b101};
        vecs[6] = '{16'h1234, 16'h0001, 1'b1, 2'd1, 1'b1, 16'hFFFF, 3'b010};
        vecs[7] = '{16'hAAAA, 16'h00FF, 1'b0, 2'd3, 1'b0, 16'hFF00, 3'b010};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 2'd2, 1'b1, 16'h0000, 3'b001};

        reset = 1'b1; out_ready = 1'b0; pops = 0;
        set_in(1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_c_out", 32'(c_out), 32'(0));
        chk("rst_status", 32'(status), 32'(0));
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Directed table: one op at a time, checking latency too.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, vecs[i].a, vecs[i].b, vecs[i].asel, vecs[i].op, vecs[i].ws);
            #1;
            chk("vec_in_ready", 32'(in_ready), 32'(1));
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_lat_k", 32'(out_valid), 32'(0));
            @(posedge clk); #1;
            chk("vec_lat_k1", 32'(out_valid), 32'(1));
            chk("vec_c_out", 32'(c_out), 32'(vecs[i].exp_c));
            chk("vec_status", 32'(status), 32'(vecs[i].exp_st));
            @(posedge clk); #1;
            chk("vec_drained", 32'(out_valid), 32'(0));
        end
        m_status = vecs[8].exp_st;

        // Backpressure: X, Y accepted, Z stalled, then drained in order.
        out_ready = 1'b0;
        set_in(1'b1, 16'h0011, 16'h0022, 1'b0, 2'd0, 1'b1); cycle();
        set_in(1'b1, 16'h0100, 16'h0300, 1'b0, 2'd1, 1'b1); cycle();
        set_in(1'b1, 16'h00F0, 16'h0F0F, 1'b0, 2'd2, 1'b0);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'(0));
        cycle(); cycle();
        chk("bp_hold_valid", 32'(out_valid), 32'(1));
        chk("bp_hold_c", 32'(c_out), 32'(16'h0033));
        chk("bp_in_ready_still_low", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        pops = 0;
        while (1) begin
            cycle();
            if (last_acc) break;
            if (pops > 3) break;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle();
        chk("bp_all_out", 32'(pops), 32'(3));
        chk("bp_queue_empty", 32'(exp_q.size()), 32'(0));
        cycle();
        chk("bp_idle", 32'(out_valid), 32'(0));

        // Streaming: 8 ADDs back to back, 8 results in the following window.
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, W'($urandom), W'($urandom), 1'b0, 2'd0, 1'b1);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'(1));
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        chk("stream_pops", 32'(pops), 32'(8));
        chk("stream_empty", 32'(exp_q.size()), 32'(0));

        // Reset with two ops in flight.
        out_ready = 1'b0;
        set_in(1'b1, 16'h0001, 16'h0002, 1'b0, 2'd0, 1'b1); cycle();
        set_in(1'b1, 16'h0003, 16'h0004, 1'b0, 2'd0, 1'b1); cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_status = 3'b000;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_c_out", 32'(c_out), 32'(0));
        chk("mid_rst_status", 32'(status), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        pops = 0;
        repeat (4) cycle();
        chk("mid_rst_no_stale", 32'(pops), 32'(0));

        // Randomized traffic; upstream holds data until accepted.
        last_acc = 1'b1;
        in_valid = 1'b0;
        pops = 0;
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || last_acc) begin
                set_in(1'(($urandom % 4) != 0), W'($urandom), W'($urandom),
                       1'(($urandom % 5) == 0), 2'($urandom), 1'($urandom));
                if ($urandom % 4 == 0) sout = W'($urandom % 3) ^ {W{1'($urandom)}};
            end
            out_ready = 1'(($urandom % 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
        chk("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
